// File: rtl/prog_clk_divider_if.sv
// Control/status bundle of the programmable clock divider.
// The master side programs the divisor and enable; the slave side is the divider itself.
interface prog_clk_divider_if #(
    parameter int DIV_W = 8
);
    logic             en;
    logic             div_load;
    logic [DIV_W-1:0] div_val;
    logic             clk_out;
    logic             tick;
    logic             div_pend;
    logic             load_err;
    logic [DIV_W-1:0] div_act;

    modport master (
        output en, div_load, div_val,
        input  clk_out, tick, div_pend, load_err, div_act
    );

    modport slave (
        input  en, div_load, div_val,
        output clk_out, tick, div_pend, load_err, div_act
    );
endinterface

// File: rtl/prog_clk_divider.sv
// Runtime-programmable integer divider producing a registered divided enable
// waveform and a one-cycle tick per period, all within the clk domain.
module prog_clk_divider #(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic              clk,
    input  logic              rst,
    prog_clk_divider_if.slave bus
);
    localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
    localparam logic [DIV_W:0]   ONE_X   = (DIV_W+1)'(1);
    localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_act;
    logic [DIV_W-1:0] pend_val;
    logic             div_pend;
    logic             clk_out;
    logic             tick;
    logic             load_err;

    logic             wrap;
    logic             load_ok;
    logic [DIV_W-1:0] cnt_nxt;
    logic [DIV_W-1:0] div_nxt;
    logic [DIV_W:0]   high_len;
    logic             out_nxt;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        wrap     = 1'b0;
        load_ok  = 1'b0;
        cnt_nxt  = cnt;
        div_nxt  = div_act;
        high_len = '0;
        out_nxt  = 1'b0;

        wrap    = bus.en && (cnt == div_act - ONE);
        load_ok = bus.div_load && (bus.div_val != '0);
        cnt_nxt = wrap ? '0 : cnt + ONE;

        // A new divisor is only adopted at the period boundary; a load arriving
        // on the boundary itself beats any older pending value.
        if (wrap) begin
            if (load_ok)       div_nxt = bus.div_val;
            else if (div_pend) div_nxt = pend_val;
        end

        // One extra bit keeps ceil(N/2) exact for N = 2^DIV_W-1.
        high_len = ({1'b0, div_nxt} + ONE_X) >> 1;
        out_nxt  = ({1'b0, cnt_nxt} < high_len);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= DEF_DIV - ONE;
            div_act  <= DEF_DIV;
            pend_val <= '0;
            div_pend <= 1'b0;
            clk_out  <= 1'b0;
            tick     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            load_err <= bus.div_load && (bus.div_val == '0);

            if (bus.en) begin
                cnt     <= cnt_nxt;
                div_act <= div_nxt;
                clk_out <= out_nxt;
                tick    <= (cnt_nxt == '0);
            end else begin
                tick    <= 1'b0;
            end

            // Loads are captured even while frozen; last request before the boundary wins.
            if (wrap) begin
                div_pend <= 1'b0;
            end else if (load_ok) begin
                pend_val <= bus.div_val;
                div_pend <= 1'b1;
            end
        end
    end

    assign bus.clk_out  = clk_out;
    assign bus.tick     = tick;
    assign bus.div_pend = div_pend;
    assign bus.load_err = load_err;
    assign bus.div_act  = div_act;
endmodule

// File: tb/tb_prog_clk_divider.sv
// Self-checking bench for prog_clk_divider: a cycle model pushes expected
// outputs to a scoreboard, plus directed waveform-shape checks.
module tb_prog_clk_divider;
    localparam int DIV_W       = 8;
    localparam int DEFAULT_DIV = 2;

    typedef struct packed {
        logic             clk_out;
        logic             tick;
        logic             div_pend;
        logic             load_err;
        logic [DIV_W-1:0] div_act;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    prog_clk_divider_if #(.DIV_W(DIV_W)) bus ();

    prog_clk_divider #(.DIV_W(DIV_W), .DEFAULT_DIV(DEFAULT_DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    // Reference model state (integers, so no wrap-around concerns).
    int   m_cnt, m_div, m_pval;
    logic m_pend, m_clk, m_tick, m_err;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic model(input logic r, input logic e, input logic l, input int v);
        logic ok, at_end;
        if (r) begin
            m_cnt  = DEFAULT_DIV - 1;
            m_div  = DEFAULT_DIV;
            m_pend = 1'b0;
            m_pval = 0;
            m_clk  = 1'b0;
            m_tick = 1'b0;
            m_err  = 1'b0;
        end else begin
            ok     = l && (v != 0);
            at_end = e && (m_cnt + 1 == m_div);
            m_err  = l && (v == 0);
            if (e) begin
                if (at_end) begin
                    m_cnt = 0;
                    if (ok)          m_div = v;
                    else if (m_pend) m_div = m_pval;
                end else begin
                    m_cnt = m_cnt + 1;
                end
                // High while phase is within the first ceil(N/2) cycles.
                m_clk  = (2 * m_cnt < m_div);
                m_tick = (m_cnt == 0);
            end else begin
                m_tick = 1'b0;
            end
            if (at_end) m_pend = 1'b0;
            else if (ok) begin
                m_pval = v;
                m_pend = 1'b1;
            end
        end
        sb.push_back('{clk_out: m_clk, tick: m_tick, div_pend: m_pend,
                       load_err: m_err, div_act: DIV_W'(m_div)});
    endtask

    task automatic compare_outputs();
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check("sb_clk_out",  32'(bus.clk_out),  32'(e.clk_out));
            check("sb_tick",     32'(bus.tick),     32'(e.tick));
            check("sb_div_pend", 32'(bus.div_pend), 32'(e.div_pend));
            check("sb_load_err", 32'(bus.load_err), 32'(e.load_err));
            check("sb_div_act",  32'(bus.div_act),  32'(e.div_act));
        end
    endtask

    // One clock: drive inputs, predict, clock, then sample 1 time unit after the edge.
    task automatic step(input logic r, input logic e, input logic l, input int v);
        rst          = r;
        bus.en       = e;
        bus.div_load = l;
        bus.div_val  = DIV_W'(v);
        model(r, e, l, v);
        @(posedge clk);
        #1;
        compare_outputs();
    endtask

    initial begin
        logic [15:0] pat;
        int          n, highs, lows, ticks;
        logic        found;

        bus.en = 1'b0; bus.div_load = 1'b0; bus.div_val = '0;

        // Reset state.
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check("rst_clk_out", 32'(bus.clk_out), 32'd0);
        check("rst_div_act", 32'(bus.div_act), 32'd2);
        check("rst_pend",    32'(bus.div_pend), 32'd0);

        // Default divide-by-2.
        pat = '0;
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 0, 0);
            pat = {pat[14:0], bus.clk_out};
        end
        check("div2_pattern", 32'(pat[5:0]), 32'b101010);

        // Mid-period load of 5 waits for the boundary.
        step(0, 1, 0, 0);
        step(0, 1, 1, 5);
        check("div5_pending", 32'(bus.div_pend), 32'd1);
        check("div5_not_yet", 32'(bus.div_act), 32'd2);
        pat = '0; ticks = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 0, 0);
            pat = {pat[14:0], bus.clk_out};
            ticks += int'(bus.tick);
        end
        check("div5_pattern", 32'(pat[9:0]), 32'b1110011100);
        check("div5_ticks",   32'(ticks), 32'd2);
        check("div5_pend_clr", 32'(bus.div_pend), 32'd0);

        // 6 then 3 before the boundary: last load wins.
        step(0, 1, 0, 0);
        step(0, 1, 1, 6);
        step(0, 1, 1, 3);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        pat = '0;
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 0, 0);
            pat = {pat[14:0], bus.clk_out};
        end
        check("div3_act",     32'(bus.div_act), 32'd3);
        check("div3_pattern", 32'(pat[5:0]), 32'b110110);

        // Load on the wrap cycle itself applies at that wrap.
        step(0, 1, 1, 4);
        check("wrap_load_act",  32'(bus.div_act), 32'd4);
        check("wrap_load_pend", 32'(bus.div_pend), 32'd0);
        check("wrap_load_tick", 32'(bus.tick), 32'd1);

        // Freeze mid-period at N=4.
        step(0, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0);
            check("frz_clk_out", 32'(bus.clk_out), 32'd1);
            check("frz_tick",    32'(bus.tick), 32'd0);
        end
        n = 0; found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step(0, 1, 0, 0);
            n++;
            found = bus.tick;
        end
        check("frz_remaining", 32'(n), 32'd3);

        // Zero load is rejected and leaves the pending divisor intact.
        step(0, 1, 1, 7);
        step(0, 1, 1, 0);
        check("err_pulse",    32'(bus.load_err), 32'd1);
        check("err_pend",     32'(bus.div_pend), 32'd1);
        check("err_act",      32'(bus.div_act), 32'd4);
        step(0, 1, 0, 0);
        check("err_single",   32'(bus.load_err), 32'd0);
        step(0, 1, 0, 0);
        check("err_kept_val", 32'(bus.div_act), 32'd7);

        // Divide-by-1: constant high, tick every cycle.
        step(0, 1, 1, 1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(0, 1, 0, 0);
            found = bus.tick;
        end
        check("div1_reached", 32'(found), 32'd1);
        highs = 0; ticks = 0;
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0, 0);
            highs += int'(bus.clk_out);
            ticks += int'(bus.tick);
        end
        check("div1_highs", 32'(highs), 32'd5);
        check("div1_ticks", 32'(ticks), 32'd5);

        // Reset mid-period with a load pending and another load presented.
        step(0, 1, 1, 9);
        step(0, 1, 1, 6);
        check("pre_rst_pend", 32'(bus.div_pend), 32'd1);
        step(1, 1, 1, 3);
        check("rst2_clk_out", 32'(bus.clk_out), 32'd0);
        check("rst2_tick",    32'(bus.tick), 32'd0);
        check("rst2_pend",    32'(bus.div_pend), 32'd0);
        check("rst2_act",     32'(bus.div_act), 32'd2);

        // Maximum divisor: 128 high, 127 low.
        step(0, 1, 1, 255);
        check("max_act", 32'(bus.div_act), 32'd255);
        highs = int'(bus.clk_out); lows = int'(!bus.clk_out);
        for (int i = 0; i < 254; i++) begin
            step(0, 1, 0, 0);
            highs += int'(bus.clk_out);
            lows  += int'(!bus.clk_out);
        end
        check("max_high", 32'(highs), 32'd128);
        check("max_low",  32'(lows),  32'd127);
        step(0, 1, 0, 0);
        check("max_next_tick", 32'(bus.tick), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
